// File: rtl/bcd_timer_ctrl_if.sv
// Command/strobe bundle between the button logic, the timer controller and
// the four BCD digit counters.
interface bcd_timer_ctrl_if;
  // No valid/ready here: start_stop and clear are one-cycle pulses sampled on
  // every posedge, and each dig_* strobe is a one-cycle command that the digit
  // counters must act on in that cycle (there is no backpressure).
  logic        start_stop;
  logic        clear;
  logic        mode;
  logic [15:0] digits_in;
  logic [3:0]  dig_up;
  logic [3:0]  dig_down;
  logic [3:0]  dig_set0;
  logic [3:0]  dig_set9;
  logic        running;
  logic        done;

  modport master (
    output start_stop, clear, mode, digits_in,
    input  dig_up, dig_down, dig_set0, dig_set9, running, done
  );

  modport slave (
    input  start_stop, clear, mode, digits_in,
    output dig_up, dig_down, dig_set0, dig_set9, running, done
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch/countdown sequencer: tick prescaler plus run/pause FSM that strobes
// every digit needing a step in the same cycle, so the counter chain never ripples.
module bcd_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  bcd_timer_ctrl_if.slave  bus,
  output logic [1:0]       state_dbg
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          mode_q;
  logic [PW-1:0] presc;

  logic       tick;
  logic [3:0] is9;
  logic [3:0] is0;
  logic [3:0] up_mask;
  logic [3:0] down_mask;

  // A/F-range digits compare unequal to both 9 and 0, so they never carry/borrow.
  assign is9 = {bus.digits_in[15:12] == 4'd9, bus.digits_in[11:8] == 4'd9,
                bus.digits_in[7:4]   == 4'd9, bus.digits_in[3:0]  == 4'd9};
  assign is0 = {bus.digits_in[15:12] == 4'd0, bus.digits_in[11:8] == 4'd0,
                bus.digits_in[7:4]   == 4'd0, bus.digits_in[3:0]  == 4'd0};

  // Digit i steps when every lower digit is at its wrap value.
  assign up_mask   = {is9[2] & is9[1] & is9[0], is9[1] & is9[0], is9[0], 1'b1};
  assign down_mask = {is0[2] & is0[1] & is0[0], is0[1] & is0[0], is0[0], 1'b1};

  assign tick      = (state == RUN) && (presc == LAST);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      presc        <= '0;
      bus.dig_up   <= 4'h0;
      bus.dig_down <= 4'h0;
      bus.dig_set0 <= 4'hF;
      bus.dig_set9 <= 4'h0;
      bus.running  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.dig_up   <= 4'h0;
      bus.dig_down <= 4'h0;
      bus.dig_set0 <= 4'h0;
      bus.dig_set9 <= 4'h0;

      if (bus.clear) begin
        state       <= IDLE;
        presc       <= '0;
        bus.running <= 1'b0;
        bus.done    <= 1'b0;
        if (bus.mode) bus.dig_set9 <= 4'hF;
        else          bus.dig_set0 <= 4'hF;
      end else begin
        // The prescaler keeps counting on the cycle a pause is requested, so
        // RUN cycles between ticks always add up to TICK_DIV.
        if (state == RUN) presc <= tick ? '0 : presc + PW'(1);

        if (bus.start_stop) begin
          case (state)
            IDLE: begin
              state       <= RUN;
              mode_q      <= bus.mode;
              presc       <= '0;
              bus.running <= 1'b1;
            end
            RUN: begin
              state       <= PAUSE;
              bus.running <= 1'b0;
            end
            PAUSE: begin
              state       <= RUN;
              bus.running <= 1'b1;
            end
            default: ;
          endcase
        end else if (tick) begin
          if (!mode_q) begin
            if (&is9) begin
              state       <= DONE;
              bus.running <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              bus.dig_up <= up_mask;
            end
          end else begin
            if (&is0) begin
              state       <= DONE;
              bus.running <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              bus.dig_down <= down_mask;
            end
          end
        end
      end
    end
  end

endmodule
